// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit controller: FSM state encoding,
// register offsets and STATUS register bit positions.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   // Register offsets within the block; only bit 2 is decoded.
   localparam logic [3:0] TXDATA_OFS = 4'h0;
   localparam logic [3:0] STATUS_OFS = 4'h4;

   // STATUS register layout.
   localparam int STATUS_BUSY_BIT  = 0;
   localparam int STATUS_FULL_BIT  = 1;
   localparam int STATUS_EMPTY_BIT = 2;
   localparam int STATUS_OVF_BIT   = 3;
   localparam int STATUS_CNT_LSB   = 4;
   localparam int STATUS_CNT_MSB   = 6;

endpackage

// File: rtl/tx_byte_fifo.sv
// Byte-wide transmit FIFO with synchronous push/pop and an occupancy count.
// The head byte is presented combinationally on dout. A push into a full FIFO
// is only accepted when a pop happens in the same cycle.
module tx_byte_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap modulo DEPTH; count tracks accepted pushes minus pops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmitter: TXDATA pushes bytes into a small FIFO,
// STATUS reports busy/full/empty/overflow/count. The FSM drains the FIFO and
// serialises 8N1 frames, chaining frames with no idle gap while bytes remain.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        tx_serial
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_t     state;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_reg;
   logic          overflow;

   logic          is_status;
   logic          push;
   logic          pop;
   logic          clr_ovf;
   logic          baud_done;
   logic [7:0]    head;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [31:0]   status;
   logic          unused_bits;

   // Only addr[2] selects between TXDATA and STATUS.
   assign is_status   = (addr[2] == STATUS_OFS[2]);
   assign push        = sel & wr_en & ~is_status;
   assign clr_ovf     = sel & wr_en & is_status;
   assign baud_done   = (baud_cnt == BW'(CLKS_PER_BIT - 1));
   assign unused_bits = ^{addr[3], addr[1:0], wdata[31:8], TXDATA_OFS};

   // A byte is taken from the FIFO when idle, or at the end of a stop bit.
   assign pop = (fifo_count != '0) &&
                ((state == ST_IDLE) || ((state == ST_STOP) && baud_done));

   tx_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (wdata[7:0]),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Assemble the STATUS word; unused bits stay zero.
   always_comb begin
      status = '0;
      status[STATUS_BUSY_BIT]                = (state != ST_IDLE);
      status[STATUS_FULL_BIT]                = fifo_full;
      status[STATUS_EMPTY_BIT]               = fifo_empty;
      status[STATUS_OVF_BIT]                 = overflow;
      status[STATUS_CNT_MSB:STATUS_CNT_LSB]  = 3'(fifo_count);
   end

   // Zero-latency read path; TXDATA reads and unselected cycles return 0.
   assign rdata = (sel & rd_en & is_status) ? status : 32'h0;

   // Sticky overflow: set by a dropped push, cleared by any STATUS write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end else if (push && fifo_full && !pop) begin
         overflow <= 1'b1;
      end
   end

   // Frame FSM with baud counter, bit index, shift register and registered line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         tx_serial <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               tx_serial <= 1'b1;
               baud_cnt  <= '0;
               bit_idx   <= '0;
               if (fifo_count != '0) begin
                  shift_reg <= head;
                  tx_serial <= 1'b0;
                  state     <= ST_START;
               end
            end
            ST_START: begin
               if (baud_done) begin
                  baud_cnt  <= '0;
                  tx_serial <= shift_reg[0];
                  state     <= ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            ST_DATA: begin
               if (baud_done) begin
                  baud_cnt  <= '0;
                  shift_reg <= shift_reg >> 1;
                  if (bit_idx == 3'd7) begin
                     bit_idx   <= '0;
                     tx_serial <= 1'b1;
                     state     <= ST_STOP;
                  end else begin
                     bit_idx   <= bit_idx + 3'd1;
                     tx_serial <= shift_reg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            ST_STOP: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (fifo_count != '0) begin
                     shift_reg <= head;
                     tx_serial <= 1'b0;
                     state     <= ST_START;
                  end else begin
                     tx_serial <= 1'b1;
                     state     <= ST_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            default: begin
               state     <= ST_IDLE;
               tx_serial <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, number of transmit byte slots (power of two).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 sel  input  1  bus select, driven by the bus address decoder.
REQ-006 wr_en  input  1  store strobe from the DM stage (MemWrite).
REQ-007 rd_en  input  1  load strobe from the DM stage (MemRead).
REQ-008 addr  input  4  byte offset within the block; only addr[2] decodes.
REQ-009 wdata  input  32  store data.
REQ-010 rdata  output  32  load data, combinational.
REQ-011 tx_serial  output  1  UART line; idle high.

Function
REQ-012 SHALL map offset 0x0 (addr[2]=0) to TXDATA: a write with sel&wr_en pushes wdata[7:0] into the FIFO at the clock edge.
REQ-013 SHALL map offset 0x4 (addr[2]=1) to STATUS:
- bit0 busy: FSM not IDLE
- bit1 full
- bit2 empty
- bit3 overflow (sticky)
- bits[6:4] count
- other bits 0
REQ-014 A write to STATUS SHALL clear overflow; wdata is ignored.
REQ-015 rdata SHALL be STATUS when sel&rd_en&addr[2], else 32'h0; a TXDATA read returns 0. rdata has zero-cycle latency.
REQ-016 A push when the FIFO is full and no pop occurs that cycle SHALL drop the byte, set overflow, and leave FIFO contents unchanged.
REQ-017 A simultaneous push and pop SHALL both take effect with count unchanged, including when the FIFO is full.
REQ-018 SHALL have FSM states IDLE, START, DATA, STOP.
REQ-019 IDLE: tx_serial=1. If the registered count is non-zero: pop the head byte into the shift register and go to START. A byte written at edge N therefore starts at edge N+1.
REQ-020 START: tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-021 DATA: shift out 8 bits LSB first, each for CLKS_PER_BIT cycles. A 3-bit index advances 0..7, then go to STOP.
REQ-022 STOP: tx_serial=1 for CLKS_PER_BIT cycles. At the end: if the FIFO is non-empty, pop and go directly to START (no gap); else go to IDLE.
REQ-023 The baud counter SHALL count 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). It resets to 0 on every state or bit transition.
REQ-024 One frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Count SHALL be $clog2(FIFO_DEPTH)+1 bits and saturate at neither end (guarded by REQ-016/019).
REQ-026 tx_serial SHALL be a registered output, glitch-free.

Reset
REQ-027 On reset, regardless of any frame in flight:
- tx_serial=1
- state=IDLE
- FIFO empty, pointers 0
- overflow=0
- baud counter and bit index 0
- shift register 0
REQ-028 After reset deassertion, the first push SHALL behave per REQ-019 with no residual frame.

Structure
REQ-029 Package uart_pkg SHALL hold:
- state enum
- offsets TXDATA_OFS=4'h0, STATUS_OFS=4'h4
- STATUS bit positions
REQ-030 The FIFO SHALL be a sub-module tx_byte_fifo (8-bit, synchronous push/pop, full/empty/count, async reset). The FSM, baud counter and register decode live in uart_tx_ctrl.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 Write 0x55 to TXDATA at edge N.
- count=1 after N.
- tx_serial goes 0 after N+1.
- Line then carries 0,1,0,1,0,1,0,1,0,1, each bit for 4 cycles.
- busy=0 by N+42.
REQ-032 Write 0xA1 and 0x3C on consecutive cycles.
- Two frames are transmitted back to back with no idle-high gap between the stop bit and the second start bit.
- Total 80 cycles of activity.
REQ-033 Write 6 bytes in 6 consecutive cycles while IDLE. The first is popped at the second edge.
- Bytes 1-5 are accepted.
- Byte 6 is dropped.
- STATUS reads full=1, overflow=1.
- A STATUS write clears overflow only.
REQ-034 With FIFO full and the FSM finishing STOP, push in the same cycle as the pop.
- Byte accepted, count stays 4, overflow stays 0.
REQ-035 Assert reset mid-DATA of byte 0xFF with 2 bytes queued.
- tx_serial=1 immediately (asynchronous).
- STATUS reads 32'h4 after release.
- No further frames follow.
REQ-036 Read STATUS with sel=0, and read TXDATA.
- rdata=0 in both cases, same cycle.
